// File: rtl/imm_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : imm_instr_encoder
// Purpose  : Packs decoded RV64 LOAD / STORE / BRANCH fields plus a 64-bit
//            signed immediate into a 32-bit instruction word, rejects
//            immediates that do not fit the format, and tags every emitted
//            word with a running byte address for instruction-memory writes.
//            Valid/ready on both sides, one output register stage.
// Options  : define ENC_RTYPE_EN to encode fmt 2'b11 as an R-type word
//            (funct7 taken from in_imm[6:0]); otherwise fmt 2'b11 is rejected.
// Revision : 1.0  initial release
// ============================================================================
module imm_instr_encoder #(
    parameter int          ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [63:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_pulse,
    output logic [7:0]        err_cnt
);

    localparam logic [1:0]        c_FMT_LOAD   = 2'b00;
    localparam logic [1:0]        c_FMT_STORE  = 2'b01;
    localparam logic [1:0]        c_FMT_BRANCH = 2'b10;
    localparam logic [6:0]        c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]        c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0]        c_OPC_BRANCH = 7'b1100011;
`ifdef ENC_RTYPE_EN
    localparam logic [6:0]        c_OPC_RTYPE  = 7'b0110011;
`endif
    localparam logic [ADDR_W-1:0] c_BASE       = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] c_STEP       = ADDR_W'(4);
    localparam logic [7:0]        c_CNT_MAX    = 8'hFF;

    logic              r_out_valid;
    logic [31:0]       r_out_instr;
    logic [ADDR_W-1:0] r_out_addr;
    logic [ADDR_W-1:0] r_next_addr;
    logic              r_err_pulse;
    logic [7:0]        r_err_cnt;

    logic              w_accept;
    logic              w_legal;
    logic [31:0]       w_instr;
    logic              w_fits12;   // sign-extension of a 12-bit value
    logic              w_fits13;   // sign-extension of a 13-bit value

    // Upstream may only hand over a field set when the output slot is free or
    // draining this cycle; restart blocks acceptance so the address reload
    // never races with an address capture.
    assign in_ready = (!r_out_valid || out_ready) && !restart;
    assign w_accept = in_valid && in_ready;

    assign w_fits12 = (&in_imm[63:11]) || (~|in_imm[63:11]);
    assign w_fits13 = (&in_imm[63:12]) || (~|in_imm[63:12]);

    // Format-dependent legality check and bit packing of the instruction word.
    always_comb begin
        w_legal = 1'b0;
        w_instr = 32'h0000_0000;
        unique case (in_fmt)
            c_FMT_LOAD: begin
                w_legal = w_fits12;
                w_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, c_OPC_LOAD};
            end
            c_FMT_STORE: begin
                w_legal = w_fits12;
                w_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:0], c_OPC_STORE};
            end
            c_FMT_BRANCH: begin
                // Branch offsets are half-word aligned; bit 0 is not encodable.
                w_legal = w_fits13 && !in_imm[0];
                w_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], c_OPC_BRANCH};
            end
            default: begin
`ifdef ENC_RTYPE_EN
                // funct7 is carried in the low immediate bits; it is unsigned.
                w_legal = ~|in_imm[63:7];
                w_instr = {in_imm[6:0], in_rs2, in_rs1, in_funct3, in_rd,
                           c_OPC_RTYPE};
`else
                w_legal = 1'b0;
                w_instr = 32'h0000_0000;
`endif
            end
        endcase
    end

    // Output register, address counter and reject bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_instr <= 32'h0000_0000;
            r_out_addr  <= '0;
            r_next_addr <= c_BASE;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= 8'h00;
        end else begin
            r_err_pulse <= w_accept && !w_legal;

            if (w_accept && w_legal) begin
                r_out_valid <= 1'b1;
                r_out_instr <= w_instr;
                r_out_addr  <= r_next_addr;
                r_next_addr <= r_next_addr + c_STEP;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            // restart forces in_ready low, so it never coincides with a capture.
            if (restart) begin
                r_next_addr <= c_BASE;
            end

            if (w_accept && !w_legal && (r_err_cnt != c_CNT_MAX)) begin
                r_err_cnt <= r_err_cnt + 8'h01;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_addr  = r_out_addr;
    assign err_pulse = r_err_pulse;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: doc/imm_instr_encoder.md
Name: imm_instr_encoder

Overview:
- Inverse of the immediate generator. Takes decoded instruction fields plus a 64-bit signed immediate and packs them into a 32-bit RV64 instruction word.
- Checks that the immediate fits the format's range.
- Attaches a running byte address so each emitted word can be written straight into instruction memory (boot loader / self-test program builder).
- Valid/ready on both sides; one output pipeline register.

Parameters:
- ADDR_W, 10, width of byte address output; address wraps modulo 2^ADDR_W.
- BASE_ADDR, 0, address given to the first word after reset or restart (must be a multiple of 4).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- restart  in  1  reload address counter to BASE_ADDR.
- in_valid  in  1  field set valid.
- in_ready  out  1  encoder can accept.
- in_fmt  in  2  00=LOAD(I), 01=STORE(S), 10=BRANCH(B), 11=R-type (optional feature) / illegal.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct3  in  3  funct3.
- in_imm  in  64  signed immediate; byte offset for B.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  sink accepts.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address of out_instr.
- err_pulse  out  1  one-cycle pulse: previous accepted input was rejected.
- err_cnt  out  8  saturating reject count.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_instr=0, out_addr=0, err_pulse=0, err_cnt=0, next_addr=BASE_ADDR.
- Handshake:
  - in_ready = (!out_valid || out_ready) && !restart.
  - Accept when in_valid && in_ready.
  - Latency 1: an accepted legal input appears on out_* the next cycle.
- Output hold: while out_valid && !out_ready, out_instr and out_addr are held stable and in_ready=0.
- out_valid clears after out_valid && out_ready unless a new legal input is accepted in the same cycle. Back-to-back accepts give one word per cycle.
- Encoding:
  - LOAD, opcode 0000011: {imm[11:0], rs1, funct3, rd, opcode}.
  - STORE, opcode 0100011: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - BRANCH, opcode 1100011: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- Range checks:
  - LOAD and STORE are legal iff in_imm[63:11] is all 0s or all 1s.
  - BRANCH is legal iff in_imm[0]==0 and in_imm[63:12] is all 0s or all 1s.
  - fmt 11 is illegal unless the optional feature is enabled.
- Illegal input:
  - It is still consumed (handshake completes) and no word is emitted.
  - out_valid follows the normal drain rule; next_addr is unchanged.
  - err_pulse=1 for exactly the next cycle; err_cnt increments and saturates at 255.
- Address:
  - A legal accept captures next_addr into out_addr, then next_addr += 4, wrapping modulo 2^ADDR_W.
- restart:
  - next_addr := BASE_ADDR at the clock edge; in_ready=0 in that cycle so no accept can collide.
  - A pending out word is unaffected.
  - err_cnt is not cleared.
- Reset mid-transfer drops any pending word; no partial output.

Optional Feature:
- Macro ENC_RTYPE_EN.
- Defined: fmt 11 encodes R-type, opcode 0110011, as {in_imm[6:0] as funct7, rs2, rs1, funct3, rd, opcode}. It is legal iff in_imm[63:7]==0.
- Undefined: fmt 11 is always rejected (err_pulse, err_cnt++).

Test Plan:
- LOAD rd=5, rs1=2, funct3=011, imm=8 after reset, out_ready=1 -> next cycle out_instr=0x00813283, out_addr=0x000.
- STORE rs2=5, rs1=2, funct3=011, imm=-8, then BRANCH rs1=1, rs2=2, funct3=000, imm=-4 back-to-back -> 0xFE513C23 @0x000, 0xFE208EE3 @0x004 on consecutive cycles.
- BRANCH imm=3, then LOAD imm=2048 -> no out_valid; err_pulse twice; err_cnt=2; next legal word still gets address 0x000.
- Backpressure: out_ready=0 for 3 cycles with in_valid held -> out_instr stable, in_ready=0; on release, the following word appears next cycle with address +4.
- Issue 256 address-consuming words with ADDR_W=10 -> out_addr wraps 0x3FC -> 0x000. Assert restart mid-stream -> in_ready=0 that cycle; next word at BASE_ADDR.
- ENC_RTYPE_EN defined, fmt=11, rd=3, rs1=1, rs2=2, funct3=0, imm=0x20 -> 0x402081B3. Undefined -> err_pulse, no output. Assert rst_n low while out_valid=1 -> out_valid=0 immediately.
